// File: rtl/layer_result_checker.sv
// layer_result_checker
//   Compares a flattened layer output vector against a loaded expected-bit memory,
//   LANES bits per clock. A check is started by a one-cycle start pulse. The
//   checker waits SETTLE cycles, scans G groups, then reports. done pulses once
//   SETTLE+G+1 edges after the edge that sampled start.
//
// Ports
//   clk              sole clock, rising edge
//   rst              asynchronous active-high reset (expected memory is kept)
//   exp_we           expected-memory write strobe (ignored while busy)
//   exp_addr         expected-memory bit index (>= NBITS ignored)
//   exp_din          expected bit value
//   start            single-cycle check request (accepted in IDLE only)
//   dut_bits         layer outputs, bit i = output i
//   busy             high while settling or scanning
//   done             one-cycle end-of-check pulse
//   pass             last completed check had zero mismatches
//   err_count        mismatch count of current/last check
//   first_err_idx    lowest mismatching bit index
//   first_err_valid  first_err_idx holds a real mismatch
module layer_result_checker #(
    parameter int unsigned NBITS  = 784,
    parameter int unsigned LANES  = 8,
    parameter int unsigned SETTLE = 2,
    localparam int unsigned IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1,
    localparam int unsigned G     = (NBITS + LANES - 1) / LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_we,
    input  logic [IDXW-1:0]   exp_addr,
    input  logic              exp_din,
    input  logic              start,
    input  logic [NBITS-1:0]  dut_bits,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDXW:0]     err_count,
    output logic [IDXW-1:0]   first_err_idx,
    output logic              first_err_valid
);

    localparam int unsigned CW    = IDXW + 1;
    localparam int unsigned GW    = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SLOAD = (SETTLE == 0) ? 0 : SETTLE - 1;

    typedef enum logic [1:0] {StIdle, StSettle, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic [CW-1:0]     err_q, err_d;
    logic [IDXW-1:0]   fidx_q, fidx_d;
    logic              fvalid_q, fvalid_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;

    logic [NBITS-1:0]  exp_mem;
    logic [LANES-1:0]  mism;
    logic [CW-1:0]     grp_cnt;
    logic [IDXW-1:0]   low_idx;

    assign busy = (state_q == StSettle) || (state_q == StScan);

    // Expected memory: no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (exp_we && !busy && (32'(exp_addr) < NBITS)) begin
            exp_mem[exp_addr] <= exp_din;
        end
    end

    // Per-group lane compare; lanes past NBITS stay masked at 0.
    always_comb begin
        int unsigned idx;
        mism    = '0;
        grp_cnt = '0;
        low_idx = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            idx = 32'(grp_q) * LANES + 32'(l);
            if (idx < NBITS) begin
                mism[l] = dut_bits[IDXW'(idx)] ^ exp_mem[IDXW'(idx)];
            end
            grp_cnt = grp_cnt + CW'(mism[l]);
        end
        // Walk downward so the lowest mismatching lane wins.
        for (int l = int'(LANES) - 1; l >= 0; l--) begin
            if (mism[l]) begin
                low_idx = IDXW'(32'(grp_q) * LANES + 32'(l));
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        grp_d    = grp_q;
        err_d    = err_q;
        fidx_d   = fidx_q;
        fvalid_d = fvalid_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d    = '0;
                    fidx_d   = '0;
                    fvalid_d = 1'b0;
                    pass_d   = 1'b0;
                    grp_d    = '0;
                    settle_d = SW'(SLOAD);
                    state_d  = (SETTLE == 0) ? StScan : StSettle;
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    state_d = StScan;
                    grp_d   = '0;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            StScan: begin
                err_d = err_q + grp_cnt;
                if ((|mism) && !fvalid_q) begin
                    fidx_d   = low_idx;
                    fvalid_d = 1'b1;
                end
                if (grp_q == GW'(G - 1)) begin
                    state_d = StDone;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            StDone: begin
                // pass and done are registered here, so they appear on the edge leaving DONE.
                pass_d  = (err_q == '0);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            settle_q <= '0;
            grp_q    <= '0;
            err_q    <= '0;
            fidx_q   <= '0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            grp_q    <= grp_d;
            err_q    <= err_d;
            fidx_q   <= fidx_d;
            fvalid_q <= fvalid_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
        end
    end

    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = fidx_q;
    assign first_err_valid = fvalid_q;

endmodule
